imem_loader: RTL and testbench

- Boot-time program loader that writes the instruction memory which the processor's fetch path and controller later read.
- Consumes a byte stream from the UART receiver (valid-strobed bytes) and assembles little-endian 32-bit instruction words.
- Writes each word to sequential instruction-memory addresses and holds the CPU core in reset until a complete, checksum-verified image is loaded.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Bundles the UART byte input and the instruction-memory write / status outputs of the loader.
// No storage; this file only carries signals between the loader and its neighbours.
// No backpressure: the byte stream cannot be stalled and the memory write port is always ready.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  // Loader side: consumes bytes, drives the memory write port and status.
  modport master (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata, cpu_reset, done, err, err_code
  );

  // Environment side: supplies bytes, observes writes and status.
  modport slave (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata, cpu_reset, done, err, err_code
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: frames a UART byte stream into 32-bit words, writes imem, releases the CPU once verified.
// Latency: imem write pulse 1 cycle after the 4th byte of a word; done/err 1 cycle after the deciding byte.
// No backpressure: a byte may arrive every cycle and is always consumed (ignored once DONE or ERROR).
module imem_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 64,
  parameter int unsigned       TIMEOUT   = 1000000
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.master bus
);

  // Idle counter only needs to reach TIMEOUT-1 before the limit fires.
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t state, state_n;

  // Frame parsing state.
  logic [7:0]        cnt_lo;
  logic [15:0]       words_rem;
  logic [1:0]        byte_idx;
  logic [23:0]       shift;      // first three bytes of the word in progress, newest on top
  logic [7:0]        csum;
  logic [TW-1:0]     tmo_cnt;

  // Output registers, kept apart from the shift register so assembly of the next word
  // can start while the previous write pulse is still on the bus.
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [1:0]        err_code;

  // Combinational decode of the current cycle.
  logic              word_wr;
  logic              timed;
  logic              tmo_hit;
  logic [1:0]        err_code_n;
  logic [15:0]       count_n;

  // Next-state logic: frame sequencing, checksum decision, count limit and idle timeout.
  always_comb begin
    state_n    = state;
    word_wr    = 1'b0;
    err_code_n = err_code;
    count_n    = {bus.rx_data, cnt_lo};
    timed      = (state == CNT_HI) || (state == DATA) || (state == CHECK);
    // A byte arriving on the limit cycle wins over the timeout.
    tmo_hit    = timed && !bus.rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));

    case (state)
      IDLE: begin
        if (bus.rx_valid) state_n = CNT_HI;
      end
      CNT_HI: begin
        if (bus.rx_valid) begin
          if ({16'd0, count_n} > MAX_WORDS) begin
            state_n    = ERROR;
            err_code_n = 2'b01;
          end else if (count_n == 16'd0) begin
            state_n = CHECK;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (bus.rx_valid && (byte_idx == 2'd3)) begin
          word_wr = 1'b1;
          if (words_rem == 16'd1) state_n = CHECK;
        end
      end
      CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum) begin
            state_n = DONE;
          end else begin
            state_n    = ERROR;
            err_code_n = 2'b10;
          end
        end
      end
      default: ; // DONE and ERROR hold until reset
    endcase

    if (tmo_hit) begin
      state_n    = ERROR;
      err_code_n = 2'b11;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Datapath: byte assembly, running XOR, word count, idle timer and the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lo     <= '0;
      words_rem  <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      csum       <= '0;
      tmo_cnt    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      err_code   <= 2'b00;
    end else begin
      err_code <= err_code_n;
      imem_we  <= word_wr;

      if (word_wr) imem_wdata <= {bus.rx_data, shift};
      if (imem_we) imem_addr  <= imem_addr + ADDR_W'(4);

      if (state == IDLE && bus.rx_valid) cnt_lo <= bus.rx_data;

      if (state == CNT_HI && bus.rx_valid) words_rem <= count_n;
      else if (word_wr)                    words_rem <= words_rem - 16'd1;

      if (state == DATA && bus.rx_valid) begin
        shift    <= {bus.rx_data, shift[23:8]};
        byte_idx <= byte_idx + 2'd1;
      end

      // Checksum covers the count bytes and every data byte, not the checksum byte itself.
      if (bus.rx_valid && (state == IDLE || state == CNT_HI || state == DATA))
        csum <= csum ^ bus.rx_data;

      if (!timed || bus.rx_valid) tmo_cnt <= '0;
      else if (!tmo_hit)          tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = imem_addr;
  assign bus.imem_wdata = imem_wdata;
  assign bus.cpu_reset  = (state != DONE);
  assign bus.done       = (state == DONE);
  assign bus.err        = (state == ERROR);
  assign bus.err_code   = err_code;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-level stimulus, scoreboard of expected memory writes, status checks.
// Inputs change and outputs are sampled on the falling clock edge.
// The byte stream is driven with rx_valid held for one cycle per byte, optionally back-to-back.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(
    .ADDR_W   (32),
    .BASE_ADDR(32'h0),
    .MAX_WORDS(64),
    .TIMEOUT  (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          wr_count = 0;
  logic [7:0]  tb_csum  = 8'h00;
  logic [63:0] exp_q[$];          // {addr, data} of each write still to come
  logic [63:0] exp_e;

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we !== 1'b0) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: we=%b addr=%h data=%h, no write expected",
                 bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== exp_e) begin
          errors++;
          $display("FAIL write_content: addr=%h data=%h, expected addr=%h data=%h",
                   bus.imem_addr, bus.imem_wdata, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tb_csum      = tb_csum ^ b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    tb_csum  = 8'h00;
    wr_count = 0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus.imem_we !== 1'b0)        begin errors++; $display("FAIL rst_we: got %b want 0", bus.imem_we); end
    checks++; if (bus.imem_addr !== 32'h0)     begin errors++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
    checks++; if (bus.imem_wdata !== 32'h0)    begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.imem_wdata); end
    checks++; if (bus.cpu_reset !== 1'b1)      begin errors++; $display("FAIL rst_cpu_reset: got %b want 1", bus.cpu_reset); end
    checks++; if (bus.done !== 1'b0)           begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0)            begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
    checks++; if (bus.err_code !== 2'b00)      begin errors++; $display("FAIL rst_err_code: got %b want 00", bus.err_code); end
  endtask

  task automatic test_single_word;
    logic [7:0] bytes [6] = '{8'h01, 8'h00, 8'h05, 8'h00, 8'hA0, 8'hE3};
    do_reset();
    exp_q.push_back({32'h0, 32'hE3A00005});
    foreach (bytes[i]) send_byte(bytes[i]);
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL single_pre_cpu_reset: got %b want 1", bus.cpu_reset); end
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL single_pre_done: got %b want 0", bus.done); end
    send_byte(8'h47);
    checks++; if (wr_count !== 1)         begin errors++; $display("FAIL single_writes: got %0d want 1", wr_count); end
    checks++; if (bus.done !== 1'b1)      begin errors++; $display("FAIL single_done: got %b want 1", bus.done); end
    checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL single_cpu_reset: got %b want 0", bus.cpu_reset); end
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL single_err: got %b want 0", bus.err); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [3] = '{32'h11223344, 32'hDEADBEEF, 32'h00000013};
    logic [31:0] w;
    do_reset();
    send_byte(8'h03);
    send_byte(8'h00);
    for (int k = 0; k < 3; k++) begin
      w = words[k];
      exp_q.push_back({32'(4 * k), w});
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
    end
    send_byte(tb_csum);
    idle(1);
    checks++; if (wr_count !== 3)     begin errors++; $display("FAIL b2b_writes: got %0d want 3", wr_count); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
    checks++; if (bus.done !== 1'b1)  begin errors++; $display("FAIL b2b_done: got %b want 1", bus.done); end
  endtask

  task automatic test_bad_checksum;
    logic [7:0] bytes [7] = '{8'h01, 8'h00, 8'h05, 8'h00, 8'hA0, 8'hE3, 8'h48};
    do_reset();
    exp_q.push_back({32'h0, 32'hE3A00005});
    foreach (bytes[i]) send_byte(bytes[i]);
    checks++; if (wr_count !== 1)         begin errors++; $display("FAIL badck_writes: got %0d want 1", wr_count); end
    checks++; if (bus.err !== 1'b1)       begin errors++; $display("FAIL badck_err: got %b want 1", bus.err); end
    checks++; if (bus.err_code !== 2'b10) begin errors++; $display("FAIL badck_code: got %b want 10", bus.err_code); end
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL badck_cpu_reset: got %b want 1", bus.cpu_reset); end
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL badck_done: got %b want 0", bus.done); end
    foreach (bytes[i]) send_byte(bytes[i]);
    idle(3);
    checks++; if (wr_count !== 1)         begin errors++; $display("FAIL badck_later_writes: got %0d want 1", wr_count); end
    checks++; if (bus.err_code !== 2'b10) begin errors++; $display("FAIL badck_sticky: got %b want 10", bus.err_code); end
  endtask

  task automatic test_overflow;
    do_reset();
    send_byte(8'h40);
    send_byte(8'h00);
    idle(2);
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL ovf_max_ok: got err %b want 0", bus.err); end
    do_reset();
    send_byte(8'h41);
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL ovf_early: got err %b want 0", bus.err); end
    send_byte(8'h00);
    checks++; if (bus.err !== 1'b1)       begin errors++; $display("FAIL ovf_err: got %b want 1", bus.err); end
    checks++; if (bus.err_code !== 2'b01) begin errors++; $display("FAIL ovf_code: got %b want 01", bus.err_code); end
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    checks++; if (wr_count !== 0)         begin errors++; $display("FAIL ovf_writes: got %0d want 0", wr_count); end
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL ovf_cpu_reset: got %b want 1", bus.cpu_reset); end
  endtask

  task automatic test_timeout;
    do_reset();
    idle(40);
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL tmo_idle_state: got err %b want 0", bus.err); end
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h05);
    idle(15);
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL tmo_early: got err %b want 0", bus.err); end
    idle(1);
    checks++; if (bus.err !== 1'b1)       begin errors++; $display("FAIL tmo_err: got %b want 1", bus.err); end
    checks++; if (bus.err_code !== 2'b11) begin errors++; $display("FAIL tmo_code: got %b want 11", bus.err_code); end
    checks++; if (wr_count !== 0)         begin errors++; $display("FAIL tmo_writes: got %0d want 0", wr_count); end
    do_reset();
    exp_q.push_back({32'h0, 32'hE3A00005});
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h05);
    idle(15);
    send_byte(8'h00);
    send_byte(8'hA0);
    send_byte(8'hE3);
    send_byte(8'h47);
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL tmo_edge_err: got %b want 0", bus.err); end
    checks++; if (bus.done !== 1'b1)      begin errors++; $display("FAIL tmo_edge_done: got %b want 1", bus.done); end
    checks++; if (wr_count !== 1)         begin errors++; $display("FAIL tmo_edge_writes: got %0d want 1", wr_count); end
  endtask

  task automatic test_zero_and_midreset;
    logic [7:0] bytes [7] = '{8'h01, 8'h00, 8'h05, 8'h00, 8'hA0, 8'hE3, 8'h47};
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++; if (bus.done !== 1'b1)      begin errors++; $display("FAIL zero_done: got %b want 1", bus.done); end
    checks++; if (wr_count !== 0)         begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_count); end
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h77);
    send_byte(8'h66);
    do_reset();
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr: got %h want 0", bus.imem_addr); end
    exp_q.push_back({32'h0, 32'hE3A00005});
    foreach (bytes[i]) send_byte(bytes[i]);
    idle(2);
    checks++; if (wr_count !== 1)         begin errors++; $display("FAIL midrst_writes: got %0d want 1", wr_count); end
    checks++; if (bus.done !== 1'b1)      begin errors++; $display("FAIL midrst_done: got %b want 1", bus.done); end
    checks++; if (exp_q.size() !== 0)     begin errors++; $display("FAIL midrst_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bad_checksum();
    test_overflow();
    test_timeout();
    test_zero_and_midreset();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
